asg_core: RTL and testbench

Arbitrary signal generator: a CPU-writable waveform table of 2^CWM samples is played out on an AXI4-Stream source, either continuously with a fixed-point phase accumulator or in triggered bursts. Each burst has a data part, an idle part, a repeat count and an optional infinite mode. The block sits between the system bus (table load and config registers upstream) and the DAC/stream path.

---
 rtl/asg_pkg.sv | 27 ++
 rtl/asg_buf.sv | 52 +++++
 rtl/asg_core.sv | 232 +++++++++++++++++++++++
 tb/tb_asg_core.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/asg_pkg.sv
// Shared types for the arbitrary signal generator: sample type, default
// pointer/counter widths and the generator FSM state encoding.
package asg_pkg;

    localparam int DWO     = 14;
    localparam int CWM_DEF = 14;
    localparam int CWF_DEF = 16;
    localparam int CWL_DEF = 32;
    localparam int CWN_DEF = 16;
    localparam int BUS_DW  = 32;

    typedef logic signed [DWO-1:0]               asg_smp_t;
    typedef logic [CWM_DEF+CWF_DEF-1:0]          asg_ptr_t;
    typedef logic [CWL_DEF-1:0]                  asg_bln_t;
    typedef logic [CWN_DEF-1:0]                  asg_bnm_t;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } asg_state_t;

    // Sign-extend a table sample to the bus data width.
    function automatic logic [BUS_DW-1:0] asg_sext(input asg_smp_t s);
        return {{(BUS_DW-DWO){s[DWO-1]}}, s};
    endfunction

endpackage

// File: rtl/asg_buf.sv
// Waveform table RAM: bus port for load/readback, generator port with a
// registered, enable-gated read so it doubles as the stream data register.
module asg_buf
    import asg_pkg::*;
#(
    parameter int CWM = CWM_DEF
) (
    input  logic           i_clk,
    input  logic           i_rstn,
    input  logic           i_a_wen,
    input  logic           i_a_ren,
    input  logic [CWM-1:0] i_a_addr,
    input  asg_smp_t       i_a_wdat,
    output asg_smp_t       o_a_rdat,
    input  logic           i_b_en,
    input  logic [CWM-1:0] i_b_addr,
    output asg_smp_t       o_b_rdat
);

    asg_smp_t r_mem [2**CWM];
    asg_smp_t r_a_rdat;
    asg_smp_t r_b_rdat;

    // Bus writes into the table.
    always_ff @(posedge i_clk) begin
        if (i_a_wen) begin
            r_mem[i_a_addr] <= i_a_wdat;
        end
    end

    // Bus readback, one cycle latency.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_a_rdat <= '0;
        end else if (i_a_ren) begin
            r_a_rdat <= r_mem[i_a_addr];
        end
    end

    // Generator read; holding i_b_en low freezes the sample under backpressure.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_b_rdat <= '0;
        end else if (i_b_en) begin
            r_b_rdat <= r_mem[i_b_addr];
        end
    end

    assign o_a_rdat = r_a_rdat;
    assign o_b_rdat = r_b_rdat;

endmodule

// File: rtl/asg_core.sv
// Arbitrary signal generator core: trigger/stop FSM, continuous phase
// accumulator, burst counters and AXI4-Stream source handshake.
module asg_core
    import asg_pkg::*;
#(
    parameter int DN  = 1,
    parameter int TN  = 1,
    parameter int CWM = CWM_DEF,
    parameter int CWF = CWF_DEF,
    parameter int CWL = CWL_DEF,
    parameter int CWN = CWN_DEF
) (
    input  logic                  clk,
    input  logic                  rstn,
    // stream source
    output logic [DN*DWO-1:0]     sto_tdata,
    output logic [DN-1:0]         sto_tkeep,
    output logic                  sto_tlast,
    output logic                  sto_tvalid,
    input  logic                  sto_tready,
    // system bus
    input  logic [31:0]           bus_addr,
    input  logic [31:0]           bus_wdata,
    input  logic                  bus_wen,
    input  logic                  bus_ren,
    output logic [31:0]           bus_rdata,
    output logic                  bus_ack,
    output logic                  bus_err,
    // control / events
    input  logic                  ctl_rst,
    input  logic [TN-1:0]         trg_i,
    output logic                  trg_o,
    output logic                  irq_trg,
    output logic                  irq_stp,
    // configuration
    input  logic [TN-1:0]         cfg_trg,
    input  logic [CWM+CWF-1:0]    cfg_siz,
    input  logic [CWM+CWF-1:0]    cfg_stp,
    input  logic [CWM+CWF-1:0]    cfg_off,
    input  logic                  cfg_ben,
    input  logic                  cfg_inf,
    input  logic [CWM-1:0]        cfg_bdl,
    input  logic [CWL-1:0]        cfg_bln,
    input  logic [CWN-1:0]        cfg_bnm,
    // status
    output logic [CWL-1:0]        sts_bln,
    output logic [CWN-1:0]        sts_bnm,
    output logic                  sts_run
);

    localparam int PW = CWM + CWF;

    asg_state_t      r_state;
    logic [PW-1:0]   r_ptr;
    logic [CWL-1:0]  r_gbln;
    logic [CWN-1:0]  r_gbnm;
    logic            r_gdone;
    logic            r_tvalid;
    logic            r_tlast;
    logic [CWL-1:0]  r_sbln;
    logic [CWN-1:0]  r_sbnm;
    logic            r_trg_o;
    logic            r_irq_trg;
    logic            r_irq_stp;
    logic            r_ack;

    logic            w_trg;
    logic            w_en;
    logic            w_hs;
    logic            w_vld_p0;
    logic            w_gwrap;
    logic            w_glast;
    logic            w_swrap;
    logic [CWM-1:0]  w_k;
    logic [CWM-1:0]  w_raddr;
    logic [PW:0]     w_psum;
    logic [PW-1:0]   w_pwrap;
    logic [PW-1:0]   w_pnext;
    asg_smp_t        w_a_rdat;
    asg_smp_t        w_b_rdat;
    logic            w_unused;

    assign w_trg    = |(trg_i & cfg_trg);
    // The output register may load whenever it is empty or being drained.
    assign w_en     = !r_tvalid || sto_tready;
    assign w_hs     = r_tvalid && sto_tready;
    assign w_vld_p0 = (r_state == RUN) && !r_gdone;

    // Burst addressing: data part walks the table, idle part holds the last sample.
    assign w_gwrap  = (r_gbln == cfg_bln);
    assign w_glast  = cfg_ben && !cfg_inf && w_gwrap && (r_gbnm == cfg_bnm);
    assign w_k      = (r_gbln < {{(CWL-CWM){1'b0}}, cfg_bdl}) ? r_gbln[CWM-1:0] : cfg_bdl;
    assign w_raddr  = cfg_ben ? (r_ptr[PW-1:CWF] + w_k) : r_ptr[PW-1:CWF];
    assign w_swrap  = (r_sbln == cfg_bln);

    // Continuous addressing: modular phase accumulator over [0, cfg_siz].
    assign w_psum   = {1'b0, r_ptr} + {1'b0, cfg_stp};
    assign w_pwrap  = w_psum[PW-1:0] - cfg_siz - PW'(1);
    assign w_pnext  = (w_psum > {1'b0, cfg_siz}) ? w_pwrap : w_psum[PW-1:0];

    asg_buf #(
        .CWM (CWM)
    ) u_buf (
        .i_clk    (clk),
        .i_rstn   (rstn),
        .i_a_wen  (bus_wen),
        .i_a_ren  (bus_ren),
        .i_a_addr (bus_addr[CWM-1:0]),
        .i_a_wdat (bus_wdata[DWO-1:0]),
        .o_a_rdat (w_a_rdat),
        .i_b_en   (w_en),
        .i_b_addr (w_raddr),
        .o_b_rdat (w_b_rdat)
    );

    // Bus acknowledge follows any access by one cycle.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_ack <= 1'b0;
        end else begin
            r_ack <= bus_wen || bus_ren;
        end
    end

    // Generator FSM: trigger start, address advance, stream valid/last, stop.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state   <= IDLE;
            r_ptr     <= '0;
            r_gbln    <= '0;
            r_gbnm    <= '0;
            r_gdone   <= 1'b0;
            r_tvalid  <= 1'b0;
            r_tlast   <= 1'b0;
            r_sbln    <= '0;
            r_sbnm    <= '0;
            r_trg_o   <= 1'b0;
            r_irq_trg <= 1'b0;
            r_irq_stp <= 1'b0;
        end else begin
            r_trg_o   <= 1'b0;
            r_irq_trg <= 1'b0;
            r_irq_stp <= 1'b0;
            if (ctl_rst) begin
                // Soft stop overrides triggers and a coinciding final beat.
                r_irq_stp <= (r_state == RUN);
                r_state   <= IDLE;
                r_tvalid  <= 1'b0;
                r_tlast   <= 1'b0;
                r_gdone   <= 1'b0;
                r_gbln    <= '0;
                r_gbnm    <= '0;
                r_sbln    <= '0;
                r_sbnm    <= '0;
            end else begin
                case (r_state)
                    IDLE: begin
                        if (w_trg) begin
                            r_state   <= RUN;
                            r_trg_o   <= 1'b1;
                            r_irq_trg <= 1'b1;
                            r_ptr     <= cfg_off;
                            r_gbln    <= '0;
                            r_gbnm    <= '0;
                            r_gdone   <= 1'b0;
                            r_tlast   <= 1'b0;
                            r_sbln    <= '0;
                            r_sbnm    <= '0;
                        end
                    end
                    RUN: begin
                        if (w_en) begin
                            r_tvalid <= w_vld_p0;
                            r_tlast  <= w_vld_p0 && w_glast;
                            if (w_vld_p0) begin
                                if (w_glast) begin
                                    r_gdone <= 1'b1;
                                end
                                if (cfg_ben) begin
                                    if (w_gwrap) begin
                                        r_gbln <= '0;
                                        r_gbnm <= r_gbnm + CWN'(1);
                                    end else begin
                                        r_gbln <= r_gbln + CWL'(1);
                                    end
                                end else begin
                                    r_ptr <= w_pnext;
                                end
                            end
                        end
                        if (w_hs) begin
                            if (cfg_ben) begin
                                if (w_swrap) begin
                                    r_sbln <= '0;
                                    r_sbnm <= r_sbnm + CWN'(1);
                                end else begin
                                    r_sbln <= r_sbln + CWL'(1);
                                end
                            end
                            if (r_tlast) begin
                                r_state   <= IDLE;
                                r_tvalid  <= 1'b0;
                                r_irq_stp <= 1'b1;
                            end
                        end
                    end
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

    // One generated sample per beat, copied to every lane.
    assign sto_tdata  = {DN{w_b_rdat}};
    assign sto_tkeep  = '1;
    assign sto_tlast  = r_tlast;
    assign sto_tvalid = r_tvalid;

    assign bus_rdata  = asg_sext(w_a_rdat);
    assign bus_ack    = r_ack;
    assign bus_err    = 1'b0;

    assign trg_o      = r_trg_o;
    assign irq_trg    = r_irq_trg;
    assign irq_stp    = r_irq_stp;
    assign sts_bln    = r_sbln;
    assign sts_bnm    = r_sbnm;
    assign sts_run    = (r_state == RUN);

    assign w_unused   = &{1'b0, bus_addr[31:CWM], bus_wdata[31:DWO]};

endmodule

// File: tb/tb_asg_core.sv
// Directed bench for asg_core: table load/readback, finite, infinite and
// continuous playout, backpressure, trigger masking and soft stop.
module tb_asg_core;

    localparam int DN  = 1;
    localparam int TN  = 1;
    localparam int CWM = 14;
    localparam int CWF = 16;
    localparam int CWL = 32;
    localparam int CWN = 16;
    localparam int PW  = CWM + CWF;

    logic              clk = 1'b0;
    logic              rstn;
    logic [DN*14-1:0]  sto_tdata;
    logic [DN-1:0]     sto_tkeep;
    logic              sto_tlast, sto_tvalid, sto_tready;
    logic [31:0]       bus_addr, bus_wdata, bus_rdata;
    logic              bus_wen, bus_ren, bus_ack, bus_err;
    logic              ctl_rst;
    logic [TN-1:0]     trg_i, cfg_trg;
    logic              trg_o, irq_trg, irq_stp;
    logic [PW-1:0]     cfg_siz, cfg_stp, cfg_off;
    logic              cfg_ben, cfg_inf;
    logic [CWM-1:0]    cfg_bdl;
    logic [CWL-1:0]    cfg_bln, sts_bln;
    logic [CWN-1:0]    cfg_bnm, sts_bnm;
    logic              sts_run;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [13:0] q_dat[$];
    bit          q_last[$];
    int          n_stp;

    always #5 clk = ~clk;

    asg_core #(
        .DN(DN), .TN(TN), .CWM(CWM), .CWF(CWF), .CWL(CWL), .CWN(CWN)
    ) dut (
        .clk(clk), .rstn(rstn),
        .sto_tdata(sto_tdata), .sto_tkeep(sto_tkeep), .sto_tlast(sto_tlast),
        .sto_tvalid(sto_tvalid), .sto_tready(sto_tready),
        .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_wen(bus_wen), .bus_ren(bus_ren),
        .bus_rdata(bus_rdata), .bus_ack(bus_ack), .bus_err(bus_err),
        .ctl_rst(ctl_rst), .trg_i(trg_i), .trg_o(trg_o), .irq_trg(irq_trg), .irq_stp(irq_stp),
        .cfg_trg(cfg_trg), .cfg_siz(cfg_siz), .cfg_stp(cfg_stp), .cfg_off(cfg_off),
        .cfg_ben(cfg_ben), .cfg_inf(cfg_inf), .cfg_bdl(cfg_bdl), .cfg_bln(cfg_bln),
        .cfg_bnm(cfg_bnm), .sts_bln(sts_bln), .sts_bnm(sts_bnm), .sts_run(sts_run)
    );

    task automatic check(input string tag, input longint act, input longint exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
        end
    endtask

    task automatic bus_wr(input int a, input logic [31:0] d);
        bus_addr  = a;
        bus_wdata = d;
        bus_wen   = 1'b1;
        @(negedge clk);
        bus_wen   = 1'b0;
    endtask

    task automatic bus_rd(input int a, output logic [31:0] d, output logic ack);
        bus_addr = a;
        bus_ren  = 1'b1;
        @(negedge clk);
        bus_ren  = 1'b0;
        d        = bus_rdata;
        ack      = bus_ack;
    endtask

    // Pulse the trigger, check start timing, then record accepted beats.
    task automatic trig_capture(input string nm, input int ncyc, input bit bp);
        q_dat.delete();
        q_last.delete();
        n_stp  = 0;
        trg_i  = 1'b1;
        @(negedge clk);
        trg_i  = 1'b0;
        check($sformatf("%s_irq_trg", nm), irq_trg, 1);
        check($sformatf("%s_trg_o", nm), trg_o, 1);
        check($sformatf("%s_vld_early", nm), sto_tvalid, 0);
        @(negedge clk);
        #1;
        check($sformatf("%s_vld_first", nm), sto_tvalid, 1);
        for (int c = 0; c < ncyc; c++) begin
            sto_tready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
            #1;
            if (sto_tvalid && sto_tready) begin
                q_dat.push_back(sto_tdata);
                q_last.push_back(sto_tlast);
            end
            if (irq_stp) n_stp++;
            @(negedge clk);
        end
        sto_tready = 1'b1;
    endtask

    task automatic check_burst(input string nm, input int bdl, input int bln, input int bnm);
        int total;
        int k;
        total = (bln + 1) * (bnm + 1);
        check($sformatf("%s_beats", nm), q_dat.size(), total);
        for (int i = 0; i < q_dat.size() && i < total; i++) begin
            k = i % (bln + 1);
            if (k > bdl) k = bdl;
            check($sformatf("%s_dat[%0d]", nm, i), q_dat[i], k);
            check($sformatf("%s_last[%0d]", nm, i), q_last[i], (i == total - 1) ? 1 : 0);
        end
        check($sformatf("%s_irq_stp", nm), n_stp, 1);
        check($sformatf("%s_run_end", nm), sts_run, 0);
    endtask

    task automatic set_burst(input bit inf, input int bdl, input int bln, input int bnm);
        cfg_ben = 1'b1;
        cfg_inf = inf;
        cfg_bdl = bdl;
        cfg_bln = bln;
        cfg_bnm = bnm;
    endtask

    // Soft stop from a running state and confirm the stream stays quiet.
    task automatic soft_stop(input string nm);
        int nv;
        ctl_rst = 1'b1;
        @(negedge clk);
        ctl_rst = 1'b0;
        check($sformatf("%s_stop_vld", nm), sto_tvalid, 0);
        check($sformatf("%s_stop_irq", nm), irq_stp, 1);
        check($sformatf("%s_stop_run", nm), sts_run, 0);
        nv = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (sto_tvalid) nv++;
        end
        check($sformatf("%s_quiet", nm), nv, 0);
    endtask

    initial begin
        logic [31:0] rd;
        logic        ack;
        int          nbad;

        rstn = 1'b0; sto_tready = 1'b1; bus_addr = '0; bus_wdata = '0;
        bus_wen = 1'b0; bus_ren = 1'b0; ctl_rst = 1'b0; trg_i = '0; cfg_trg = 1'b1;
        cfg_siz = (PW'(16) << CWF) - PW'(1); cfg_stp = PW'(1) << CWF; cfg_off = '0;
        cfg_ben = 1'b1; cfg_inf = 1'b0; cfg_bdl = '0; cfg_bln = '0; cfg_bnm = '0;

        repeat (3) @(negedge clk);
        check("rst_tvalid", sto_tvalid, 0);
        check("rst_tlast", sto_tlast, 0);
        check("rst_tdata", sto_tdata, 0);
        check("rst_run", sts_run, 0);
        check("rst_irq", {irq_trg, irq_stp, trg_o}, 0);
        check("rst_sts", {sts_bln, sts_bnm}, 0);
        check("rst_ack", bus_ack, 0);
        rstn = 1'b1;
        @(negedge clk);

        // table[i] = i, plus one negative sample for sign extension
        for (int i = 0; i < 16; i++) bus_wr(i, i);
        bus_wr(100, 32'h0000_2001);
        bus_rd(5, rd, ack);
        check("rd5_data", rd, 5);
        check("rd5_ack", ack, 1);
        check("rd5_err", bus_err, 0);
        bus_rd(100, rd, ack);
        check("rd_sext", rd, 32'hFFFF_E001);
        @(negedge clk);
        check("ack_drop", bus_ack, 0);

        // masked trigger does not start
        cfg_trg = 1'b0; trg_i = 1'b1;
        @(negedge clk);
        trg_i = 1'b0;
        @(negedge clk);
        check("mask_run", sts_run, 0);
        check("mask_irq", irq_trg, 0);
        cfg_trg = 1'b1;

        // trigger coinciding with soft stop stays idle
        trg_i = 1'b1; ctl_rst = 1'b1;
        @(negedge clk);
        trg_i = 1'b0; ctl_rst = 1'b0;
        check("trgrst_run", sts_run, 0);
        check("trgrst_irq", irq_trg, 0);
        check("trgrst_stp", irq_stp, 0);

        // single-sample periods: N beats, all sample 0
        for (int n = 1; n <= 4; n++) begin
            set_burst(1'b0, 0, 0, n - 1);
            trig_capture($sformatf("t1n%0d", n), n + 6, 1'b0);
            check_burst($sformatf("t1n%0d", n), 0, 0, n - 1);
        end

        // data then idle: 3 periods of 0..6,6
        set_burst(1'b0, 6, 7, 2);
        trig_capture("t2", 34, 1'b0);
        check_burst("t2", 6, 7, 2);

        // full data: 4 periods of 0..7
        set_burst(1'b0, 7, 7, 3);
        trig_capture("t3", 42, 1'b0);
        check_burst("t3", 7, 7, 3);

        // backpressure on the data/idle case
        set_burst(1'b0, 6, 7, 2);
        trig_capture("t6", 160, 1'b1);
        check_burst("t6", 6, 7, 2);

        // infinite bursts until soft stop
        set_burst(1'b1, 0, 7, 0);
        trig_capture("t4", 40, 1'b0);
        check("t4_many", (q_dat.size() > 8) ? 1 : 0, 1);
        nbad = 0;
        foreach (q_dat[i]) if (q_dat[i] != 0 || q_last[i]) nbad++;
        check("t4_bad_beats", nbad, 0);
        check("t4_no_stp", n_stp, 0);
        check("t4_running", sts_run, 1);
        soft_stop("t4");

        // continuous: step 2 over a 16-sample table
        cfg_ben = 1'b0; cfg_inf = 1'b0;
        cfg_stp = PW'(2) << CWF;
        cfg_siz = (PW'(16) << CWF) - PW'(1);
        trig_capture("t5", 30, 1'b0);
        check("t5_many", (q_dat.size() >= 20) ? 1 : 0, 1);
        for (int i = 0; i < q_dat.size(); i++) begin
            check($sformatf("t5_dat[%0d]", i), q_dat[i], (2 * i) % 16);
            check($sformatf("t5_last[%0d]", i), q_last[i], 0);
        end
        check("t5_running", sts_run, 1);
        soft_stop("t5");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "timeout");
    end

endmodule
